// File: rtl/cpu_out_uart_if.sv
// cpu_out_uart_if: byte handshake between the CPU output port and the UART FIFO.
interface cpu_out_uart_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/cpu_out_uart.sv
// cpu_out_uart: buffers CPU OUT bytes in a small FIFO and sends them as 8N1 serial on tx.
// Optional even-parity bit between the data bits and the stop bit: define CPU_OUT_UART_PARITY_EN.
module cpu_out_uart #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  cpu_out_uart_if.slave                cpu,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

`ifdef CPU_OUT_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           tx_q, tx_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
`ifdef CPU_OUT_UART_PARITY_EN
  logic           par_q, par_d;
`endif

  logic full, empty, push, pop, bit_end;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // A full FIFO refuses the byte even if a pop happens on the same edge.
  assign push    = cpu.out_valid & ~full;
  assign bit_end = (baud_q == BAUD_LAST);

  assign cpu.out_ready = ~full;
  assign busy          = (state_q != S_IDLE) | ~empty;
  assign tx            = tx_q;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;

  // FIFO write side, occupancy and sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q | (cpu.out_valid & full);
    if (push) begin
      mem_d[wr_ptr_q] = cpu.out_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Line FSM: tx_d is the line level for the state being entered, so tx is registered.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;
`ifdef CPU_OUT_UART_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef CPU_OUT_UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef CPU_OUT_UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when another byte is waiting.
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      shreg_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef CPU_OUT_UART_PARITY_EN
      par_d    = ^mem_q[rd_ptr_q];
`endif
    end
  end

  // State registers; reset aborts any frame and discards queued bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
`ifdef CPU_OUT_UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
`ifdef CPU_OUT_UART_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_out_uart.sv
// tb_cpu_out_uart: directed checks of cpu_out_uart framing, FIFO fill/overflow and reset.
module tb_cpu_out_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef CPU_OUT_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FC = FB * CPB;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 = start, 1..8 = data LSB first, 9 = stop
    logic       par;    // even parity of data
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx, busy, overflow;
  logic [CW-1:0] fifo_count;
  int            tests = 0;
  int            fails = 0;

  cpu_out_uart_if bus();

  cpu_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input vec_t v, input int b);
    if (b < 9) return v.frame[b];
`ifdef CPU_OUT_UART_PARITY_EN
    if (b == 9) return v.par;
`endif
    return 1'b1;
  endfunction

  // Push one byte into an idle UART and check the whole frame cycle by cycle.
  task automatic send_frame(input vec_t v);
    bus.out_data  = v.data;
    bus.out_valid = 1'b1;
    tick();
    bus.out_valid = 1'b0;
    check($sformatf("push_count_%02h", v.data), fifo_count, 1);
    check($sformatf("push_tx_idle_%02h", v.data), tx, 1);
    for (int c = 0; c < FC; c++) begin
      tick();
      check($sformatf("frame_%02h_cyc%0d", v.data, c), tx, exp_bit(v, c / CPB));
    end
    check($sformatf("busy_last_stop_%02h", v.data), busy, 1);
    tick();
    check($sformatf("busy_end_%02h", v.data), busy, 0);
    check($sformatf("count_end_%02h", v.data), fifo_count, 0);
  endtask

  vec_t vecs[5];
  vec_t b2b[2];
  int   fill_cnt[6];
  logic txq[$];

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010, par: 1'b0};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000, par: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110, par: 1'b0};
    vecs[3] = '{data: 8'h07, frame: 10'b1000001110, par: 1'b1};
    vecs[4] = '{data: 8'h3C, frame: 10'b1001111000, par: 1'b0};
    b2b[0]  = '{data: 8'h01, frame: 10'b1000000010, par: 1'b1};
    b2b[1]  = '{data: 8'h80, frame: 10'b1100000000, par: 1'b1};
    fill_cnt = '{1, 1, 2, 3, 4, 4};

    bus.out_data  = 8'h00;
    bus.out_valid = 1'b0;

    // Reset held for two cycles.
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_ready", bus.out_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);

    // Single frames from the vector table.
    foreach (vecs[i]) send_frame(vecs[i]);

    // Back-to-back: second start bit follows first stop bit with no gap.
    begin
      int peak;
      bus.out_data  = b2b[0].data;
      bus.out_valid = 1'b1;
      tick();
      check("b2b_count0", fifo_count, 1);
      bus.out_data = b2b[1].data;
      tick();
      bus.out_valid = 1'b0;
      check("b2b_count1", fifo_count, 1);
      peak = fifo_count;
      check("b2b_cyc0", tx, 0);
      for (int c = 1; c < 2 * FC; c++) begin
        tick();
        if (fifo_count > peak) peak = fifo_count;
        check($sformatf("b2b_cyc%0d", c), tx, exp_bit(b2b[c / FC], (c % FC) / CPB));
      end
      check("b2b_peak", peak, 1);
      check("b2b_busy_last", busy, 1);
      tick();
      check("b2b_busy_end", busy, 0);
    end

    // Fill to full, overflow on the sixth byte, line carries 0x10..0x14.
    for (int k = 0; k < 6; k++) begin
      bus.out_data  = 8'h10 + 8'(k);
      bus.out_valid = 1'b1;
      tick();
      check($sformatf("fill_count_%0d", k), fifo_count, fill_cnt[k]);
      if (k >= 1) txq.push_back(tx);
      if (k == 4) check("fill_ready_full", bus.out_ready, 0);
    end
    bus.out_valid = 1'b0;
    check("fill_overflow", overflow, 1);
    while (txq.size() < 5 * FC) begin
      tick();
      txq.push_back(tx);
    end
    for (int j = 0; j < 5; j++) begin
      logic [7:0] rx;
      for (int b = 0; b < 8; b++) rx[b] = txq[(j * FB + 1 + b) * CPB + CPB / 2];
      check($sformatf("fill_start_%0d", j), txq[j * FC + CPB / 2], 0);
      check($sformatf("fill_byte_%0d", j), rx, 8'h10 + 8'(j));
      check($sformatf("fill_stop_%0d", j), txq[(j * FB + FB - 1) * CPB + CPB / 2], 1);
    end
    tick();
    check("fill_busy_end", busy, 0);
    check("fill_overflow_sticky", overflow, 1);

    // Reset during DATA bit 3 of 0xFF with two bytes queued.
    bus.out_valid = 1'b1;
    bus.out_data  = 8'hFF; tick();
    bus.out_data  = 8'h11; tick();
    bus.out_data  = 8'h22; tick();
    bus.out_valid = 1'b0;
    check("mid_queued", fifo_count, 2);
    repeat (16) tick();
    check("mid_busy", busy, 1);
    check("mid_bit3", tx, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overflow", overflow, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    begin
      int bad = 0;
      for (int c = 0; c < 100; c++) begin
        tick();
        if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("mid_no_frames", bad, 0);
      check("mid_count_after", fifo_count, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_out_uart.md
Name: cpu_out_uart

Overview:
- Downstream consumer of the CPU's 8-bit output port (`cpu_out`).
- Captures each byte the CPU emits on an OUT strobe into a small FIFO, then serialises it as 8N1 asynchronous serial on `tx`.
- Decouples CPU execution rate from line rate, so OUT instructions do not stall unless the FIFO is full.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; integer >= 2 (small default for simulation).
- FIFO_DEPTH, 4, byte entries in the output FIFO; power of 2, >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- out_data  input  8  byte from CPU output port (`cpu_out`).
- out_valid  input  1  CPU presents a byte this cycle.
- out_ready  output  1  FIFO can accept; equals !full.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently stored.
- overflow  output  1  sticky; set when out_valid=1 while out_ready=0.

Behaviour:
- Reset (async, reset=0) forces:
  - tx=1, busy=0, fifo_count=0, out_ready=1, overflow=0.
  - FSM=IDLE, bit counter=0, baud counter=0.
  - Reset mid-frame aborts the frame immediately; FIFO contents are discarded.
- Push: on a clock edge with out_valid & out_ready, out_data is written at wr_ptr, wr_ptr increments modulo FIFO_DEPTH.
- Full rule: when full, out_ready=0 and the push is refused, even if a pop occurs on the same edge.
  - out_valid=1 while full drops the byte and sets overflow=1.
  - overflow clears only on reset.
- Pop: occurs only on the FSM transitions into START described below; rd_ptr increments modulo FIFO_DEPTH.
- Count: simultaneous push and pop leaves fifo_count unchanged; pointers wrap independently.
- Shift register: 8 bits, loaded on pop, shifted right each data bit; tx = shreg[0] in DATA (LSB first).
- FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
  - IDLE: tx=1. If FIFO non-empty at an edge, pop the head byte and enter START.
    - Latency: a push at edge N into an empty FIFO in IDLE gives pop plus tx=0 after edge N+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: each bit held CLKS_PER_BIT cycles. After bit 7 completes, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its final cycle:
    - if FIFO non-empty, pop and go directly to START (back-to-back, no idle gap);
    - else go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles per byte.
- Baud counter: counts 0..CLKS_PER_BIT-1 within each bit and resets on every state or bit change.
- busy = (state != IDLE) | (fifo_count != 0).
- All outputs are registered except out_ready and busy, which are combinational from registered state.

Optional Feature:
- Macro: CPU_OUT_UART_PARITY_EN.
- Defined:
  - A PARITY state follows DATA; tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
  - Frame is 11*CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state and no parity logic; frame is 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset check: hold reset=0 for 2 cycles, release.
  - Required: tx=1, out_ready=1, busy=0, fifo_count=0, overflow=0.
- Single byte: CLKS_PER_BIT=4, push 0xA5 at edge N.
  - Required: tx=0 from edge N+1 for 4 cycles.
  - Then data bits 1,0,1,0,0,1,0,1 (4 cycles each), then tx=1 for 4 cycles.
  - busy falls after edge N+41.
- Back-to-back: push 0x01 then 0x80 on consecutive edges.
  - Required: second start bit begins on the edge immediately after the first stop bit's 4th cycle (no idle gap).
  - fifo_count peaks at 1.
- Fill/overflow: from IDLE, out_valid=1 for 6 consecutive edges with bytes 0x10..0x15.
  - Required: fifo_count 1,1,2,3,4; out_ready=0 after the 5th edge.
  - 0x15 is dropped and overflow=1.
  - Line carries 0x10..0x14 in order.
- Reset mid-frame: assert reset during DATA bit 3 of 0xFF with 2 bytes queued.
  - Required: tx=1 immediately (asynchronously); after release fifo_count=0, no further frames emitted.
- Parity (CPU_OUT_UART_PARITY_EN): send 0x07.
  - Required: parity bit=1 before stop; frame is 44 cycles at CLKS_PER_BIT=4.
